// File: rtl/npc_pkg.sv
// npc_pkg: shared widths, ALU one-hot bit indices and register index type for the NPC core
package npc_pkg;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int RIDX_W = $clog2(NREG);
   localparam int ALU_AUIPC = 0;
   localparam int ALU_LUI   = 1;
   localparam int ALU_JAL   = 2;
   localparam int ALU_JALR  = 3;
   localparam int ALU_ADDI  = 4;
   localparam int ALU_ADD   = 5;
   localparam int ALU_LW    = 6;
   localparam int ALU_LBU   = 7;
   typedef logic [RIDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/npc_regfile.sv
// npc_regfile: 2-read/1-write integer register file with async active-low clear and hardwired x0.
// Ports: clk, reset (async, active-low), rs1_i/rs2_i read addresses with combinational
// rdata1_o/rdata2_o, rd_i/wen_i/wdata_i write port committed on the rising clk edge.
module npc_regfile
   import npc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  reg_idx_t        rs1_i,
   input  reg_idx_t        rs2_i,
   input  reg_idx_t        rd_i,
   input  logic            wen_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata1_o,
   output logic [XLEN-1:0] rdata2_o
);
   logic [XLEN-1:0] regs_q [NREG];
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      else if (wen_i && rd_i != '0)
         regs_q[rd_i] <= wdata_i;
   assign rdata1_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
   assign rdata2_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];
endmodule

// File: rtl/npc_exec_unit.sv
// npc_exec_unit: execute/writeback datapath (register file, AND-OR result ALU, funct3 one-hot decode).
// Ports: clk, reset (async, active-low); funct3 -> hot_funct3; rs1/rs2 -> src1/src2;
// rd/wen write back result; imm, pc, rdata and one-hot alu_op select the result.
module npc_exec_unit
   import npc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [2:0]      funct3,
   output logic [7:0]      hot_funct3,
   input  reg_idx_t        rs1,
   input  reg_idx_t        rs2,
   input  reg_idx_t        rd,
   input  logic            wen,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rdata,
   input  logic [7:0]      alu_op,
   output logic [XLEN-1:0] src1,
   output logic [XLEN-1:0] src2,
   output logic [XLEN-1:0] result
);
   logic [XLEN-1:0] pc_imm, link, s1_imm, s1_s2;
   npc_regfile u_regfile (
      .clk      (clk),
      .reset    (reset),
      .rs1_i    (rs1),
      .rs2_i    (rs2),
      .rd_i     (rd),
      .wen_i    (wen),
      .wdata_i  (result),
      .rdata1_o (src1),
      .rdata2_o (src2)
   );
   assign hot_funct3 = 8'd1 << funct3;
   assign pc_imm = pc + imm;
   assign link   = pc + XLEN'(4);
   assign s1_imm = src1 + imm;
   assign s1_s2  = src1 + src2;
   // One-hot AND-OR mux: an all-zero select yields zero, several bits OR their terms.
   always_comb
      result = ({XLEN{alu_op[ALU_AUIPC]}}                    & pc_imm)
             | ({XLEN{alu_op[ALU_LUI]}}                      & imm)
             | ({XLEN{alu_op[ALU_JAL] | alu_op[ALU_JALR]}}   & link)
             | ({XLEN{alu_op[ALU_ADDI]}}                     & s1_imm)
             | ({XLEN{alu_op[ALU_ADD]}}                      & s1_s2)
             | ({XLEN{alu_op[ALU_LW] | alu_op[ALU_LBU]}}     & rdata);
endmodule

// File: tb/tb_npc_exec_unit.sv
// tb_npc_exec_unit: directed self-checking bench for npc_exec_unit
module tb_npc_exec_unit;
   localparam logic [7:0] OP_AUIPC = 8'h01;
   localparam logic [7:0] OP_LUI   = 8'h02;
   localparam logic [7:0] OP_JAL   = 8'h04;
   localparam logic [7:0] OP_JALR  = 8'h08;
   localparam logic [7:0] OP_ADDI  = 8'h10;
   localparam logic [7:0] OP_ADD   = 8'h20;
   localparam logic [7:0] OP_LW    = 8'h40;
   localparam logic [7:0] OP_LBU   = 8'h80;
   logic        clk, reset, wen;
   logic [2:0]  funct3;
   logic [7:0]  hot_funct3, alu_op;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm, pc, rdata, src1, src2, result;
   int n_tests, n_fail;
   npc_exec_unit dut (
      .clk        (clk),
      .reset      (reset),
      .funct3     (funct3),
      .hot_funct3 (hot_funct3),
      .rs1        (rs1),
      .rs2        (rs2),
      .rd         (rd),
      .wen        (wen),
      .imm        (imm),
      .pc         (pc),
      .rdata      (rdata),
      .alu_op     (alu_op),
      .src1       (src1),
      .src2       (src2),
      .result     (result)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic lui_write(input logic [4:0] r, input logic [31:0] v);
      @(negedge clk);
      alu_op = OP_LUI; imm = v; rd = r; wen = 1'b1;
      tick();
      @(negedge clk);
      wen = 1'b0; alu_op = 8'h00;
   endtask
   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      lui_write(5'd5, 32'h55);
      rs1 = 5'd5; #1;
      n_tests++; if (src1 !== 32'h55) begin n_fail++; $display("FAIL rst_prewrite src1=%h exp=%h", src1, 32'h55); end
      reset = 1'b0; rs2 = 5'd5; #1;
      n_tests++; if (src1 !== 32'h0) begin n_fail++; $display("FAIL rst_src1 src1=%h exp=0", src1); end
      n_tests++; if (src2 !== 32'h0) begin n_fail++; $display("FAIL rst_src2 src2=%h exp=0", src2); end
      alu_op = OP_LUI; imm = 32'h99; rd = 5'd5; wen = 1'b1;
      tick();
      n_tests++; if (src1 !== 32'h0) begin n_fail++; $display("FAIL rst_held_write src1=%h exp=0", src1); end
      @(negedge clk);
      wen = 1'b0; alu_op = 8'h00;
      #1 reset = 1'b1;
      lui_write(5'd1, 32'h1234);
      rs1 = 5'd1; rs2 = 5'd5; #1;
      n_tests++; if (src1 !== 32'h00001234) begin n_fail++; $display("FAIL rst_lui_x1 src1=%h exp=%h", src1, 32'h1234); end
      n_tests++; if (src2 !== 32'h0) begin n_fail++; $display("FAIL rst_x5_cleared src2=%h exp=0", src2); end
   endtask
   task automatic test_x0();
      lui_write(5'd2, 32'hFFFF_FFFF);
      lui_write(5'd4, 32'h3);
      @(negedge clk);
      rs1 = 5'd4; rs2 = 5'd4; rd = 5'd0; alu_op = OP_ADD; wen = 1'b1; #1;
      n_tests++; if (result !== 32'h6) begin n_fail++; $display("FAIL x0_add_result result=%h exp=6", result); end
      tick();
      @(negedge clk);
      wen = 1'b0; rs1 = 5'd0; rs2 = 5'd0; #1;
      n_tests++; if (src1 !== 32'h0) begin n_fail++; $display("FAIL x0_src1 src1=%h exp=0", src1); end
      n_tests++; if (src2 !== 32'h0) begin n_fail++; $display("FAIL x0_src2 src2=%h exp=0", src2); end
   endtask
   task automatic test_wrap();
      @(negedge clk);
      rs1 = 5'd2; imm = 32'h1; alu_op = OP_ADDI; #1;
      n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL addi_wrap result=%h exp=0", result); end
      pc = 32'h8000_0000; imm = 32'h0000_1000; alu_op = OP_AUIPC; #1;
      n_tests++; if (result !== 32'h8000_1000) begin n_fail++; $display("FAIL auipc result=%h exp=%h", result, 32'h8000_1000); end
      rs1 = 5'd2; rs2 = 5'd4; alu_op = OP_ADD; #1;
      n_tests++; if (result !== 32'h2) begin n_fail++; $display("FAIL add_wrap result=%h exp=2", result); end
   endtask
   task automatic test_link_load();
      @(negedge clk);
      pc = 32'h8000_0010; alu_op = OP_JAL; #1;
      n_tests++; if (result !== 32'h8000_0014) begin n_fail++; $display("FAIL jal result=%h exp=%h", result, 32'h8000_0014); end
      alu_op = OP_JALR; #1;
      n_tests++; if (result !== 32'h8000_0014) begin n_fail++; $display("FAIL jalr result=%h exp=%h", result, 32'h8000_0014); end
      rdata = 32'hDEAD_BEEF; alu_op = OP_LW; #1;
      n_tests++; if (result !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw result=%h exp=%h", result, 32'hDEAD_BEEF); end
      rdata = 32'h0000_00AB; alu_op = OP_LBU; rd = 5'd7; wen = 1'b1; #1;
      n_tests++; if (result !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu result=%h exp=%h", result, 32'hAB); end
      tick();
      @(negedge clk);
      wen = 1'b0; alu_op = 8'h00; rs1 = 5'd7; #1;
      n_tests++; if (src1 !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu_wb src1=%h exp=%h", src1, 32'hAB); end
   endtask
   task automatic test_decoder();
      logic [7:0] exp_hot [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      for (int f = 0; f < 8; f++) begin
         funct3 = 3'(f); #1;
         n_tests++; if (hot_funct3 !== exp_hot[f]) begin n_fail++; $display("FAIL hot_funct3[%0d] got=%h exp=%h", f, hot_funct3, exp_hot[f]); end
      end
      pc = 32'h1000; imm = 32'h55; rdata = 32'h77; rs1 = 5'd1; rs2 = 5'd1; alu_op = 8'h00; #1;
      n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL alu_op_zero result=%h exp=0", result); end
   endtask
   task automatic test_self_add();
      lui_write(5'd5, 32'h21);
      @(negedge clk);
      rs1 = 5'd5; rs2 = 5'd5; rd = 5'd5; alu_op = OP_ADD; wen = 1'b1; #1;
      n_tests++; if (result !== 32'h42) begin n_fail++; $display("FAIL self_add_pre result=%h exp=%h", result, 32'h42); end
      tick();
      n_tests++; if (src1 !== 32'h42) begin n_fail++; $display("FAIL self_add_wb src1=%h exp=%h", src1, 32'h42); end
      @(negedge clk);
      wen = 1'b0; alu_op = 8'h00;
   endtask
   task automatic test_bypass_async_reset();
      lui_write(5'd3, 32'h11);
      @(negedge clk);
      alu_op = OP_LUI; imm = 32'h7; rd = 5'd3; wen = 1'b1; rs1 = 5'd3; #1;
      n_tests++; if (src1 !== 32'h11) begin n_fail++; $display("FAIL no_bypass src1=%h exp=%h", src1, 32'h11); end
      tick();
      n_tests++; if (src1 !== 32'h7) begin n_fail++; $display("FAIL post_edge src1=%h exp=7", src1); end
      @(negedge clk);
      wen = 1'b0; alu_op = 8'h00; rs2 = 5'd1;
      #2 reset = 1'b0;
      #1;
      n_tests++; if (src1 !== 32'h0) begin n_fail++; $display("FAIL async_rst_src1 src1=%h exp=0", src1); end
      n_tests++; if (src2 !== 32'h0) begin n_fail++; $display("FAIL async_rst_src2 src2=%h exp=0", src2); end
      @(negedge clk);
      reset = 1'b1;
   endtask
   initial begin
      n_tests = 0; n_fail = 0;
      reset = 1'b0; wen = 1'b0; funct3 = 3'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
      imm = '0; pc = '0; rdata = '0; alu_op = 8'h00;
      test_reset();
      test_x0();
      test_wrap();
      test_link_load();
      test_decoder();
      test_self_add();
      test_bypass_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
